// File: rtl/mult32x32_seq.sv
// Sequencer that drives an external 32x32 multi-cycle multiplier and optionally
// accumulates its 64-bit products. Busy-handshake timeout sets a sticky error.
module mult32x32_seq #(
  parameter int BUSY_TMO = 4,
  parameter bit ACC_EN   = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic        in_acc,
  input  logic        in_clr,
  output logic        mult_start,
  output logic [31:0] mult_a,
  output logic [31:0] mult_b,
  input  logic        mult_busy,
  input  logic [63:0] mult_product,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        out_ovf,
  output logic        err
);

  localparam int CNT_W = (BUSY_TMO > 1) ? $clog2(BUSY_TMO) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(BUSY_TMO - 1);

  typedef enum logic [2:0] {IDLE, START, WAIT_HI, WAIT_LO, RESULT} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [31:0]      a_reg, b_reg;
  logic             acc_op_reg, clr_reg;
  logic [63:0]      acc_reg;
  logic [63:0]      out_data_reg;
  logic             out_ovf_reg;
  logic             err_reg;

  logic             accept, capture, timeout;
  logic             acc_in;
  logic [63:0]      acc_base;
  logic [64:0]      sum;
  logic [63:0]      res_data;
  logic             res_ovf;

  assign acc_in = ACC_EN && in_acc;

  assign acc_base = clr_reg ? 64'd0 : acc_reg;
  assign sum      = {1'b0, acc_base} + {1'b0, mult_product};
  assign res_data = acc_op_reg ? sum[63:0] : mult_product;
  assign res_ovf  = acc_op_reg & sum[64];

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    accept     = 1'b0;
    capture    = 1'b0;
    timeout    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          accept     = 1'b1;
          state_next = START;
        end
      end
      START: begin
        cnt_next   = '0;
        // A multiplier that is already busy skips the rising-edge wait.
        state_next = mult_busy ? WAIT_LO : WAIT_HI;
      end
      WAIT_HI: begin
        if (mult_busy) begin
          state_next = WAIT_LO;
        end else if (cnt_reg == TMO_LAST) begin
          timeout    = 1'b1;
          state_next = RESULT;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      WAIT_LO: begin
        if (!mult_busy) begin
          capture    = 1'b1;
          state_next = RESULT;
        end
      end
      RESULT: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      acc_op_reg   <= 1'b0;
      clr_reg      <= 1'b0;
      acc_reg      <= '0;
      out_data_reg <= '0;
      out_ovf_reg  <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        a_reg      <= in_a;
        b_reg      <= in_b;
        acc_op_reg <= acc_in;
        clr_reg    <= in_clr;
      end
      if (capture) begin
        out_data_reg <= res_data;
        out_ovf_reg  <= res_ovf;
        acc_reg      <= res_data;
      end
      // Timeout leaves the accumulator untouched.
      if (timeout) begin
        out_data_reg <= '0;
        out_ovf_reg  <= 1'b0;
        err_reg      <= 1'b1;
      end
    end
  end

  assign in_ready   = (state_reg == IDLE);
  assign mult_start = (state_reg == START);
  assign out_valid  = (state_reg == RESULT);
  assign mult_a     = a_reg;
  assign mult_b     = b_reg;
  assign out_data   = out_data_reg;
  assign out_ovf    = out_ovf_reg;
  assign err        = err_reg;

endmodule
